// File: rtl/axi_rd_burst_seq.sv
// axi_rd_burst_seq
// Splits one large read command into AXI-legal bursts (no 4 KB crossing,
// capped at MAX_BURST_BYTES, FIXED bursts capped at 16 beats), issues them
// over a valid/ready request port with at most MAX_OUT in flight, and
// collects the burst responses into a sticky status for the owning FSM.
//
// Optional feature macro: AXI_RD_SEQ_ERR_ABORT_EN
//   defined   - a non-OKAY response stops further issue; remaining bytes
//               are abandoned and the command finishes with error_o = 1.
//   undefined - every burst is issued; errors are only reported.
module axi_rd_burst_seq #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int CW              = 24,
    parameter int MAX_BURST_BYTES = 256,
    parameter int MAX_OUT         = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] src_addr_i,
    input  logic [CW-1:0] byte_cnt_i,
    input  logic          fixed_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    output logic [1:0]    resp_o,
    output logic          req_valid_o,
    input  logic          req_ready_i,
    output logic [AW-1:0] req_addr_o,
    output logic [CW-1:0] req_byte_len_o,
    output logic          req_fixed_o,
    output logic          req_lock_o,
    input  logic [1:0]    req_resp_i,
    input  logic          req_resp_valid_i
);

    localparam int            BC        = DW / 8;
    localparam logic [CW-1:0] BC_C      = CW'(BC);
    localparam logic [CW-1:0] MAXB_C    = CW'(MAX_BURST_BYTES);
    localparam logic [CW-1:0] FIXB_C    = CW'(16 * BC);
    localparam logic [2:0]    MAX_OUT_C = 3'(MAX_OUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;       // address of the next burst to present
    logic [CW-1:0] rem_q, rem_d;         // bytes not yet presented
    logic          fixed_q, fixed_d;
    logic [2:0]    out_q, out_d;         // bursts handshaken but not yet answered
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [1:0]    resp_q, resp_d;
    logic          req_valid_q, req_valid_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic [CW-1:0] req_len_q, req_len_d;

    // Burst-size calculator inputs: the command ports while idle (so the
    // first burst is presented on the accepting edge), the latched
    // remainder otherwise.
    logic [AW-1:0] sz_addr;
    logic [CW-1:0] sz_rem;
    logic          sz_fixed;
    logic [12:0]   to_page;
    logic [CW-1:0] lim_page;
    logic [CW-1:0] lim;
    logic [CW-1:0] size;

    logic          hs;
    logic [2:0]    out_nx;
    logic [1:0]    resp_nx;
    logic          error_nx;
    logic          abort;
    logic          present;
    logic          finish;

    // Size of the burst that would be presented next.
    always_comb begin
        sz_addr  = (state_q == IDLE) ? src_addr_i : addr_q;
        sz_rem   = (state_q == IDLE) ? byte_cnt_i : rem_q;
        sz_fixed = (state_q == IDLE) ? fixed_i    : fixed_q;
        to_page  = 13'd4096 - {1'b0, sz_addr[11:0]};
        lim_page = sz_fixed ? FIXB_C : CW'(to_page);
        lim      = (lim_page < MAXB_C) ? lim_page : MAXB_C;
        size     = (sz_rem < lim) ? sz_rem : lim;
    end

    // Next-state and next-output computation.
    // NOTE: every variable gets a default at the top so no path can leave
    // one unassigned (which would infer a latch); blocking '=' is correct
    // here because this block describes combinational logic.
    always_comb begin
        hs       = req_valid_q & req_ready_i;
        out_nx   = out_q + {2'b00, hs} - {2'b00, req_resp_valid_i};
        resp_nx  = resp_q | (req_resp_valid_i ? req_resp_i : 2'b00);
        error_nx = error_q | (req_resp_valid_i & req_resp_i[1]);
`ifdef AXI_RD_SEQ_ERR_ABORT_EN
        abort    = error_nx;
`else
        abort    = 1'b0;
`endif
        present     = 1'b0;
        finish      = 1'b0;
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        fixed_d     = fixed_q;
        out_d       = out_nx;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_nx;
        resp_d      = resp_nx;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_len_d   = req_len_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (byte_cnt_i != '0) begin
                        fixed_d = fixed_i;
                        resp_d  = 2'b00;
                        error_d = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ISSUE;
                        present = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (req_valid_q && !req_ready_i) begin
                    // presented request is held until accepted
                end else if (rem_q != '0 && !abort && out_nx < MAX_OUT_C) begin
                    present = 1'b1;
                end else begin
                    req_valid_d = 1'b0;
                    if (rem_q == '0 || abort) begin
                        if (out_nx == 3'd0) finish  = 1'b1;
                        else                state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_nx == 3'd0) finish = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (present) begin
            req_valid_d = 1'b1;
            req_addr_d  = sz_addr;
            req_len_d   = size - BC_C;
            rem_d       = sz_rem - size;
            addr_d      = sz_fixed ? sz_addr : sz_addr + AW'(size);
        end

        if (finish) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    // State and registered outputs; reset abandons any in-flight bursts.
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples the pre-edge values; all registers are plain flops (no
    // memory array), so each one is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            fixed_q     <= 1'b0;
            out_q       <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            resp_q      <= 2'b00;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            fixed_q     <= fixed_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            resp_q      <= resp_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_len_q   <= req_len_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign resp_o         = resp_q;
    assign req_valid_o    = req_valid_q;
    assign req_addr_o     = req_addr_q;
    assign req_byte_len_o = req_len_q;
    assign req_fixed_o    = fixed_q;
    assign req_lock_o     = 1'b0;

endmodule
